// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller.
// Default widths, redirect source/state enums, and the issue bundle.
package fetch_redirect_ctrl_pkg;

  localparam int PC_W   = 32;
  localparam int HIST_W = 10;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CM,
    SRC_RN,
    SRC_IRQ
  } redirect_src_t;

  typedef enum logic {
    RUN,
    HOLD
  } ctrl_state_t;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [HIST_W-1:0] hist;
  } redirect_req_t;

endpackage

// File: rtl/fetch_redirect_ctrl_slot.sv
// redirect_slot: single-entry redirect holding register.
// Ports: clk, rst (sync, active-low), set/clr (clr wins), set_pc/set_hist, valid/pc/hist.
module redirect_slot
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = PC_W,
  parameter int HIST_WIDTH = HIST_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set,
  input  logic                  clr,
  input  logic [PC_WIDTH-1:0]   set_pc,
  input  logic [HIST_WIDTH-1:0] set_hist,
  output logic                  valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [HIST_WIDTH-1:0] hist
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      hist  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (set) begin
      valid <= 1'b1;
      pc    <= set_pc;
      hist  <= set_hist;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: prioritises cm / irq / rn redirects into next-PC, registered outputs.
// Ports: clk, rst, stall_i, cm_*, rn_*, irq_*, br_mispred_i, redirect_*, fetch_bubble_o,
// pending_o, redirect_cnt_o. Optional: FETCH_REDIRECT_STOP_ON_MISPRED_EN.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = PC_W,
  parameter int HIST_WIDTH = HIST_W,
  parameter int CNT_WIDTH  = 16,
  parameter int NUM_BR     = 2,
  parameter int WAIT_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  cm_valid_i,
  input  logic [PC_WIDTH-1:0]   cm_pc_i,
  input  logic [HIST_WIDTH-1:0] cm_hist_i,
  input  logic                  rn_valid_i,
  input  logic [PC_WIDTH-1:0]   rn_pc_i,
  input  logic [HIST_WIDTH-1:0] rn_hist_i,
  input  logic                  irq_req_i,
  input  logic [PC_WIDTH-1:0]   irq_pc_i,
  output logic                  irq_ack_o,
  input  logic [NUM_BR-1:0]     br_mispred_i,
  output logic                  redirect_valid_o,
  output logic [PC_WIDTH-1:0]   redirect_pc_o,
  output logic                  redirect_hist_we_o,
  output logic [HIST_WIDTH-1:0] redirect_hist_o,
  output logic                  fetch_bubble_o,
  output logic                  pending_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

  logic                  rn_full;
  logic [PC_WIDTH-1:0]   rn_pc;
  logic [HIST_WIDTH-1:0] rn_hist;
  logic                  irq_full;
  logic [PC_WIDTH-1:0]   irq_pc;
  logic [HIST_WIDTH-1:0] unused_irq_hist;

  logic rn_set, rn_clr, irq_set, irq_clr;
  logic slots_next;

  redirect_src_t src;
  redirect_req_t req;
  ctrl_state_t   state;

  // A same-cycle cm makes the rename redirect stale.
  assign rn_set  = rn_valid_i && !cm_valid_i;
  assign rn_clr  = (src != SRC_NONE);
  assign irq_set = irq_req_i && !irq_full;
  assign irq_clr = (src == SRC_IRQ);

  assign slots_next = (!rn_clr && (rn_set || rn_full)) ||
                      (!irq_clr && (irq_set || irq_full));

  always_comb begin
    src = SRC_NONE;
    if (cm_valid_i)
      src = SRC_CM;
    else if (irq_full && !stall_i)
      src = SRC_IRQ;
    else if ((rn_full || rn_valid_i) && !stall_i)
      src = SRC_RN;
  end

  always_comb begin
    req = '0;
    unique case (src)
      SRC_CM: begin
        req.valid = 1'b1;
        req.pc    = cm_pc_i;
        req.hist  = cm_hist_i;
      end
      SRC_IRQ: begin
        req.valid = 1'b1;
        req.pc    = irq_pc;
        req.hist  = redirect_hist_o;
      end
      SRC_RN: begin
        // Newest rename redirect wins over the held one.
        req.valid = 1'b1;
        req.pc    = rn_valid_i ? rn_pc_i : rn_pc;
        req.hist  = rn_valid_i ? rn_hist_i : rn_hist;
      end
      default: ;
    endcase
  end

  redirect_slot #(
    .PC_WIDTH  (PC_WIDTH),
    .HIST_WIDTH(HIST_WIDTH)
  ) u_rn_slot (
    .clk     (clk),
    .rst     (rst),
    .set     (rn_set),
    .clr     (rn_clr),
    .set_pc  (rn_pc_i),
    .set_hist(rn_hist_i),
    .valid   (rn_full),
    .pc      (rn_pc),
    .hist    (rn_hist)
  );

  redirect_slot #(
    .PC_WIDTH  (PC_WIDTH),
    .HIST_WIDTH(HIST_WIDTH)
  ) u_irq_slot (
    .clk     (clk),
    .rst     (rst),
    .set     (irq_set),
    .clr     (irq_clr),
    .set_pc  (irq_pc_i),
    .set_hist('0),
    .valid   (irq_full),
    .pc      (irq_pc),
    .hist    (unused_irq_hist)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= RUN;
      pending_o          <= 1'b0;
      irq_ack_o          <= 1'b0;
      redirect_valid_o   <= 1'b0;
      redirect_hist_we_o <= 1'b0;
      redirect_pc_o      <= '0;
      redirect_hist_o    <= '0;
      redirect_cnt_o     <= '0;
    end else begin
      unique case (state)
        RUN:  if (slots_next) state <= HOLD;
        HOLD: if (!slots_next) state <= RUN;
        default: state <= RUN;
      endcase
      pending_o          <= slots_next;
      irq_ack_o          <= irq_set;
      redirect_valid_o   <= req.valid;
      redirect_hist_we_o <= (src == SRC_CM) || (src == SRC_RN);
      if (req.valid) begin
        redirect_pc_o   <= req.pc;
        redirect_hist_o <= req.hist;
        if (redirect_cnt_o != '1)
          redirect_cnt_o <= redirect_cnt_o + 1'b1;
      end
    end
  end

`ifdef FETCH_REDIRECT_STOP_ON_MISPRED_EN
  logic [WAIT_DELAY-1:0] mis_pipe;
  logic                  bubble_q;

  always_ff @(posedge clk) begin
    if (!rst || cm_valid_i) begin
      mis_pipe <= '0;
      bubble_q <= 1'b0;
    end else begin
      for (int i = WAIT_DELAY - 1; i > 0; i--)
        mis_pipe[i] <= mis_pipe[i-1];
      mis_pipe[0] <= |br_mispred_i;
      bubble_q    <= bubble_q | mis_pipe[WAIT_DELAY-1];
    end
  end

  // The pipe tail raises the bubble in its own cycle; bubble_q keeps it.
  assign fetch_bubble_o = bubble_q | mis_pipe[WAIT_DELAY-1];
`else
  logic unused_mispred;
  assign unused_mispred = (^br_mispred_i) ^ (WAIT_DELAY > 0);
  assign fetch_bubble_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: vector table plus reset,
// saturation and mispredict-bubble sequences.
module tb_fetch_redirect_ctrl;

`ifdef FETCH_REDIRECT_STOP_ON_MISPRED_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        cm_valid_i;
  logic [31:0] cm_pc_i;
  logic [9:0]  cm_hist_i;
  logic        rn_valid_i;
  logic [31:0] rn_pc_i;
  logic [9:0]  rn_hist_i;
  logic        irq_req_i;
  logic [31:0] irq_pc_i;
  logic        irq_ack_o;
  logic [1:0]  br_mispred_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_hist_we_o;
  logic [9:0]  redirect_hist_o;
  logic        fetch_bubble_o;
  logic        pending_o;
  logic [15:0] redirect_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .cm_valid_i        (cm_valid_i),
    .cm_pc_i           (cm_pc_i),
    .cm_hist_i         (cm_hist_i),
    .rn_valid_i        (rn_valid_i),
    .rn_pc_i           (rn_pc_i),
    .rn_hist_i         (rn_hist_i),
    .irq_req_i         (irq_req_i),
    .irq_pc_i          (irq_pc_i),
    .irq_ack_o         (irq_ack_o),
    .br_mispred_i      (br_mispred_i),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .redirect_hist_we_o(redirect_hist_we_o),
    .redirect_hist_o   (redirect_hist_o),
    .fetch_bubble_o    (fetch_bubble_o),
    .pending_o         (pending_o),
    .redirect_cnt_o    (redirect_cnt_o)
  );

  typedef struct {
    logic        stall;
    logic        cm;
    logic [31:0] cm_pc;
    logic [9:0]  cm_h;
    logic        rn;
    logic [31:0] rn_pc;
    logic [9:0]  rn_h;
    logic        irq;
    logic [31:0] irq_pc;
    logic        v;
    logic [31:0] pc;
    logic        we;
    logic [9:0]  h;
    logic        pend;
    logic        ack;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input int st, input int cm, input int cpc, input int ch,
    input int rn, input int rpc, input int rh,
    input int iq, input int ipc,
    input int v, input int pc, input int we, input int h,
    input int pd, input int ak, input int cn);
    vec_t r;
    r.stall = st[0];  r.cm = cm[0];
    r.cm_pc = cpc;    r.cm_h = ch[9:0];
    r.rn = rn[0];     r.rn_pc = rpc; r.rn_h = rh[9:0];
    r.irq = iq[0];    r.irq_pc = ipc;
    r.v = v[0];       r.pc = pc;     r.we = we[0];
    r.h = h[9:0];     r.pend = pd[0]; r.ack = ak[0];
    r.cnt = cn[15:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_i = 0; cm_valid_i = 0; cm_pc_i = 0; cm_hist_i = 0;
    rn_valid_i = 0; rn_pc_i = 0; rn_hist_i = 0;
    irq_req_i = 0; irq_pc_i = 0; br_mispred_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v,
                         input logic [31:0] pc, input logic we,
                         input logic [9:0] h, input logic pd,
                         input logic ak, input logic [15:0] cn);
    chk({nm, ".valid"}, 32'(redirect_valid_o), 32'(v));
    chk({nm, ".pc"}, redirect_pc_o, pc);
    chk({nm, ".we"}, 32'(redirect_hist_we_o), 32'(we));
    chk({nm, ".hist"}, 32'(redirect_hist_o), 32'(h));
    chk({nm, ".pend"}, 32'(pending_o), 32'(pd));
    chk({nm, ".ack"}, 32'(irq_ack_o), 32'(ak));
    chk({nm, ".cnt"}, 32'(redirect_cnt_o), 32'(cn));
  endtask

  initial begin
    //               st cm cpc    ch    rn rpc    rh    iq ipc
    //               v  pc     we h     pd ak cnt
    vecs[0]  = mk(0,0,0,0,       0,0,0,          0,0,
                  0,0,0,0,             0,0,0);
    vecs[1]  = mk(1,0,0,0,       1,'h1000,'h15,  0,0,
                  0,0,0,0,             1,0,0);
    vecs[2]  = mk(1,0,0,0,       0,0,0,          0,0,
                  0,0,0,0,             1,0,0);
    vecs[3]  = mk(1,0,0,0,       0,0,0,          0,0,
                  0,0,0,0,             1,0,0);
    vecs[4]  = mk(0,0,0,0,       0,0,0,          0,0,
                  1,'h1000,1,'h15,     0,0,1);
    vecs[5]  = mk(0,0,0,0,       0,0,0,          0,0,
                  0,'h1000,0,'h15,     0,0,1);
    vecs[6]  = mk(1,1,'h2000,'h2a, 1,'h3000,'h3f, 0,0,
                  1,'h2000,1,'h2a,     0,0,2);
    vecs[7]  = mk(0,0,0,0,       0,0,0,          0,0,
                  0,'h2000,0,'h2a,     0,0,2);
    vecs[8]  = mk(0,0,0,0,       0,0,0,          0,0,
                  0,'h2000,0,'h2a,     0,0,2);
    vecs[9]  = mk(1,0,0,0,       1,'h1000,'h11,  0,0,
                  0,'h2000,0,'h2a,     1,0,2);
    vecs[10] = mk(1,0,0,0,       0,0,0,          1,'h80,
                  0,'h2000,0,'h2a,     1,1,2);
    vecs[11] = mk(0,0,0,0,       0,0,0,          1,'h80,
                  1,'h80,0,'h2a,       0,0,3);
    vecs[12] = mk(0,0,0,0,       0,0,0,          0,0,
                  0,'h80,0,'h2a,       0,0,3);
    vecs[13] = mk(0,1,'h4000,'h01, 0,0,0,        1,'h90,
                  1,'h4000,1,'h01,     1,1,4);
    vecs[14] = mk(1,0,0,0,       0,0,0,          1,'h90,
                  0,'h4000,0,'h01,     1,0,4);
    vecs[15] = mk(0,0,0,0,       0,0,0,          0,0,
                  1,'h90,0,'h01,       0,0,5);
    vecs[16] = mk(1,0,0,0,       1,'h5000,'h05,  0,0,
                  0,'h90,0,'h01,       1,0,5);
    vecs[17] = mk(1,0,0,0,       1,'h6000,'h06,  0,0,
                  0,'h90,0,'h01,       1,0,5);
    vecs[18] = mk(0,0,0,0,       0,0,0,          0,0,
                  1,'h6000,1,'h06,     0,0,6);
    vecs[19] = mk(0,0,0,0,       1,'h7000,'h07,  0,0,
                  1,'h7000,1,'h07,     0,0,7);
    vecs[20] = mk(1,1,'h8000,'h08, 0,0,0,        0,0,
                  1,'h8000,1,'h08,     0,0,8);
    vecs[21] = mk(0,0,0,0,       0,0,0,          0,0,
                  0,'h8000,0,'h08,     0,0,8);

    idle_inputs();
    rst = 0;
    #2;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.bubble", 32'(fetch_bubble_o), 0);
    rst = 1;

    for (int i = 0; i < NV; i++) begin
      stall_i    = vecs[i].stall;
      cm_valid_i = vecs[i].cm;
      cm_pc_i    = vecs[i].cm_pc;
      cm_hist_i  = vecs[i].cm_h;
      rn_valid_i = vecs[i].rn;
      rn_pc_i    = vecs[i].rn_pc;
      rn_hist_i  = vecs[i].rn_h;
      irq_req_i  = vecs[i].irq;
      irq_pc_i   = vecs[i].irq_pc;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc,
              vecs[i].we, vecs[i].h, vecs[i].pend, vecs[i].ack,
              vecs[i].cnt);
      chk($sformatf("vec%0d.bubble", i), 32'(fetch_bubble_o), 0);
    end

    // Reset while holding: held rn dropped, level irq re-latched.
    idle_inputs();
    stall_i = 1; rn_valid_i = 1; rn_pc_i = 'ha000; rn_hist_i = 'h0a;
    irq_req_i = 1; irq_pc_i = 'hc0;
    tick();
    chk_out("hold", 0, 'h8000, 0, 'h08, 1, 1, 8);
    rn_valid_i = 0;
    rst = 0;
    tick();
    chk_out("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    tick();
    chk_out("relatch", 0, 0, 0, 0, 1, 1, 0);
    irq_req_i = 0; stall_i = 0;
    tick();
    chk_out("irq_after_rst", 1, 'hc0, 0, 0, 0, 0, 1);
    tick();
    chk_out("no_rn_after_rst", 0, 'hc0, 0, 0, 0, 0, 1);

    // Counter saturation: back-to-back cm redirects.
    cm_valid_i = 1; cm_pc_i = 'hf00; cm_hist_i = 'h3;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat.cnt", 32'(redirect_cnt_o), 'hffff);
    chk("sat.valid", 32'(redirect_valid_o), 1);
    tick();
    chk("sat.hold", 32'(redirect_cnt_o), 'hffff);
    cm_valid_i = 0;
    tick();

    // Mispredict bubble, WAIT_DELAY = 2.
    idle_inputs();
    br_mispred_i = 2'b01;
    tick();
    chk("bub.n1", 32'(fetch_bubble_o), 0);
    br_mispred_i = 0;
    tick();
    chk("bub.n2", 32'(fetch_bubble_o), 32'(FEAT));
    tick();
    chk("bub.n3", 32'(fetch_bubble_o), 32'(FEAT));
    tick();
    chk("bub.n4", 32'(fetch_bubble_o), 32'(FEAT));
    cm_valid_i = 1; cm_pc_i = 'hb00; cm_hist_i = 'h2;
    tick();
    chk("bub.clr", 32'(fetch_bubble_o), 0);
    chk("bub.redir", 32'(redirect_valid_o), 1);
    chk("bub.pc", redirect_pc_o, 'hb00);
    br_mispred_i = 2'b10;
    tick();
    cm_valid_i = 0; br_mispred_i = 0;
    tick();
    tick();
    chk("bub.ign", 32'(fetch_bubble_o), 0);
    tick();
    chk("bub.ign2", 32'(fetch_bubble_o), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
